ef_sram_1024x32_arbiter: RTL and testbench

//  Shares one EF_SRAM_1024x32 macro between two requester ports (A, B) with round-robin arbitration.

---
 rtl/ef_sram_ctrl_pkg.sv | 17 +
 rtl/ef_sram_rr_arb2.sv | 37 +++
 rtl/ef_sram_1024x32_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ef_sram_1024x32_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_sram_ctrl_pkg.sv
// Shared definitions for the EF_SRAM_1024x32 two-port arbiter.
//  - state_e : controller FSM states (optional SCRUB sweep, then RUN)
//  - RD / WR : macro R_WB pin encodings
//  - TEST_PIN_TIE : functional value for every macro test/scan pin
package ef_sram_ctrl_pkg;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    localparam logic TEST_PIN_TIE = 1'b0;

endpackage

// File: rtl/ef_sram_rr_arb2.sv
// Two-input round-robin arbiter.
//  clk, rst_n : clock, asynchronous active-low reset
//  req[1:0]   : request vector (bit 0 = port A, bit 1 = port B)
//  advance    : update the last-grant pointer with the current grant
//  gnt[1:0]   : one-hot combinational grant (all zero when nothing requested)
// On a tie the port that was not granted last wins; after reset A wins.
module ef_sram_rr_arb2
    import ef_sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = port B received the most recent grant
    logic last_b;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_b)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/ef_sram_1024x32_arbiter.sv
// Shares one EF_SRAM_1024x32 macro between request ports A and B.
//  clk, rst_n            : clock (also forwarded to mem_CLKin), async active-low reset
//  x_req_valid/ready     : request handshake, ready is the combinational grant
//  x_req_we/addr/wdata/wmask : request fields (wmask bit 1 = bit written)
//  x_rsp_valid/rdata     : one-cycle read response pulse, rdata held until next response
//  init_done             : requests may be accepted
//  mem_*                 : macro pins; test/scan pins tied to their functional value
// Build option: define EF_SRAM_ARB_SCRUB_EN to zero the whole array after every reset
// before requests are accepted.
module ef_sram_1024x32_arbiter
    import ef_sram_ctrl_pkg::*;
#(
    parameter int NB = 32,
    parameter int NA = 10,
    parameter int NW = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [NA-1:0] a_req_addr,
    input  logic [NB-1:0] a_req_wdata,
    input  logic [NB-1:0] a_req_wmask,
    output logic          a_rsp_valid,
    output logic [NB-1:0] a_rsp_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [NA-1:0] b_req_addr,
    input  logic [NB-1:0] b_req_wdata,
    input  logic [NB-1:0] b_req_wmask,
    output logic          b_rsp_valid,
    output logic [NB-1:0] b_rsp_rdata,
    output logic          init_done,
    output logic          mem_CLKin,
    output logic          mem_EN,
    output logic          mem_R_WB,
    output logic [NA-1:0] mem_AD,
    output logic [NB-1:0] mem_DI,
    output logic [NB-1:0] mem_BEN,
    input  logic [NB-1:0] mem_DO,
    output logic          mem_TM,
    output logic          mem_SM,
    output logic          mem_WLBI,
    output logic          mem_WLOFF,
    output logic          mem_ScanInCC,
    output logic          mem_ScanInDL,
    output logic          mem_ScanInDR
);

    state_e        state;
    logic [NA-1:0] scrub_cnt;
    logic          scrub_go;   // keeps the macro idle while still in reset / first cycle
    logic          scrub_wr;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [NA-1:0] ad_q;
    logic [NB-1:0] di_q;
    logic [NB-1:0] ben_q;
    logic [1:0]    rd_s1;      // one-hot port id of the read the macro sampled last edge

    assign mem_CLKin    = clk;
    assign mem_TM       = TEST_PIN_TIE;
    assign mem_SM       = TEST_PIN_TIE;
    assign mem_WLBI     = TEST_PIN_TIE;
    assign mem_WLOFF    = TEST_PIN_TIE;
    assign mem_ScanInCC = TEST_PIN_TIE;
    assign mem_ScanInDL = TEST_PIN_TIE;
    assign mem_ScanInDR = TEST_PIN_TIE;

`ifdef EF_SRAM_ARB_SCRUB_EN
    assign scrub_wr = (state == ST_SCRUB) && scrub_go;
`else
    assign scrub_wr = 1'b0;
`endif

    assign req         = init_done ? {b_req_valid, a_req_valid} : 2'b00;
    assign a_req_ready = gnt[0];
    assign b_req_ready = gnt[1];

    ef_sram_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (init_done),
        .gnt     (gnt)
    );

    // Address/data/mask hold their last driven value on idle cycles to limit toggling.
    always_comb begin
        mem_EN   = 1'b0;
        mem_R_WB = RD;
        mem_AD   = ad_q;
        mem_DI   = di_q;
        mem_BEN  = ben_q;
        if (scrub_wr) begin
            mem_EN   = 1'b1;
            mem_R_WB = WR;
            mem_AD   = scrub_cnt;
            mem_DI   = '0;
            mem_BEN  = '1;
        end else if (gnt[0]) begin
            mem_EN   = 1'b1;
            mem_R_WB = a_req_we ? WR : RD;
            mem_AD   = a_req_addr;
            mem_DI   = a_req_wdata;
            mem_BEN  = a_req_wmask;
        end else if (gnt[1]) begin
            mem_EN   = 1'b1;
            mem_R_WB = b_req_we ? WR : RD;
            mem_AD   = b_req_addr;
            mem_DI   = b_req_wdata;
            mem_BEN  = b_req_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q  <= '0;
            di_q  <= '0;
            ben_q <= '0;
        end else if (mem_EN) begin
            ad_q  <= mem_AD;
            di_q  <= mem_DI;
            ben_q <= mem_BEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef EF_SRAM_ARB_SCRUB_EN
            state <= ST_SCRUB;
`else
            state <= ST_RUN;
`endif
            scrub_cnt <= '0;
            scrub_go  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                ST_SCRUB: begin
                    scrub_go <= 1'b1;
                    if (scrub_go) begin
                        if (scrub_cnt == NA'(NW - 1)) begin
                            scrub_cnt <= '0;
                            state     <= ST_RUN;
                            init_done <= 1'b1;
                        end else begin
                            scrub_cnt <= scrub_cnt + NA'(1);
                        end
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Response pipe: macro samples at edge N, DO is captured at edge N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1       <= 2'b00;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            rd_s1       <= {gnt[1] & ~b_req_we, gnt[0] & ~a_req_we};
            a_rsp_valid <= rd_s1[0];
            b_rsp_valid <= rd_s1[1];
            if (rd_s1[0]) begin
                a_rsp_rdata <= mem_DO;
            end
            if (rd_s1[1]) begin
                b_rsp_rdata <= mem_DO;
            end
        end
    end

endmodule

// File: tb/tb_ef_sram_1024x32_arbiter.sv
// Self-checking bench for ef_sram_1024x32_arbiter with a behavioural macro model,
// a reference memory/grant/response model, and directed scenarios.
module tb_ef_sram_1024x32_arbiter;

    localparam int NB = 32;
    localparam int NA = 10;
    localparam int NW = 1024;

`ifdef EF_SRAM_ARB_SCRUB_EN
    localparam int          INIT_EDGES = NW + 1;
    localparam logic [31:0] EXP_RD20   = 32'h0000_0000;
    localparam logic [31:0] EXP_3FF_RST = 32'h0000_0000;
`else
    localparam int          INIT_EDGES = 1;
    localparam logic [31:0] EXP_RD20   = 32'h8585_8585;
    localparam logic [31:0] EXP_3FF_RST = 32'hFFFF_0000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [NA-1:0] a_req_addr;
    logic [NB-1:0] a_req_wdata, a_req_wmask, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [NA-1:0] b_req_addr;
    logic [NB-1:0] b_req_wdata, b_req_wmask, b_rsp_rdata;
    logic          init_done, mem_CLKin, mem_EN, mem_R_WB;
    logic [NA-1:0] mem_AD;
    logic [NB-1:0] mem_DI, mem_BEN, mem_DO;
    logic          mem_TM, mem_SM, mem_WLBI, mem_WLOFF;
    logic          mem_ScanInCC, mem_ScanInDL, mem_ScanInDR;

    always #5 clk = ~clk;

    ef_sram_1024x32_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_req_we     (a_req_we),
        .a_req_addr   (a_req_addr),
        .a_req_wdata  (a_req_wdata),
        .a_req_wmask  (a_req_wmask),
        .a_rsp_valid  (a_rsp_valid),
        .a_rsp_rdata  (a_rsp_rdata),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_req_we     (b_req_we),
        .b_req_addr   (b_req_addr),
        .b_req_wdata  (b_req_wdata),
        .b_req_wmask  (b_req_wmask),
        .b_rsp_valid  (b_rsp_valid),
        .b_rsp_rdata  (b_rsp_rdata),
        .init_done    (init_done),
        .mem_CLKin    (mem_CLKin),
        .mem_EN       (mem_EN),
        .mem_R_WB     (mem_R_WB),
        .mem_AD       (mem_AD),
        .mem_DI       (mem_DI),
        .mem_BEN      (mem_BEN),
        .mem_DO       (mem_DO),
        .mem_TM       (mem_TM),
        .mem_SM       (mem_SM),
        .mem_WLBI     (mem_WLBI),
        .mem_WLOFF    (mem_WLOFF),
        .mem_ScanInCC (mem_ScanInCC),
        .mem_ScanInDL (mem_ScanInDL),
        .mem_ScanInDR (mem_ScanInDR)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int edges  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-up content stand-in for the (undefined) array contents
    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Macro model: samples pins at the edge, DO valid after the edge for reads.
    logic [NB-1:0] sram [NW];
    logic          primed = 1'b0;
    logic          poke = 1'b0;
    logic [NA-1:0] poke_addr = '0;
    logic [NB-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (!primed) begin
            for (int i = 0; i < NW; i++) sram[i] <= pat(i);
            primed <= 1'b1;
        end else if (poke) begin
            sram[poke_addr] <= poke_data;
        end else if (mem_EN) begin
            if (!mem_R_WB) sram[mem_AD] <= (sram[mem_AD] & ~mem_BEN) | (mem_DI & mem_BEN);
            else           mem_DO <= sram[mem_AD];
        end
    end

    // Reference model
    typedef struct {
        bit          port_b;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [31:0]   ref_mem [NW];
    bit            ref_primed = 0;
    bit            m_last_b   = 1;
    bit            need_zero  = 0;
    bit            hold_known = 0;
    logic [NA-1:0] h_ad;
    logic [NB-1:0] h_di, h_ben;
    logic [31:0]   m_a_rdata = '0;
    logic [31:0]   m_b_rdata = '0;

    always @(negedge clk) begin : cmp
        bit            ga, gb, we, exp_av, exp_bv;
        logic [NA-1:0] ad;
        logic [NB-1:0] wd, wm;
        rsp_t          e;
        if (!ref_primed) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
            ref_primed = 1;
        end
        check("tie_pins", {mem_TM, mem_SM, mem_WLBI, mem_WLOFF, mem_ScanInCC, mem_ScanInDL,
                           mem_ScanInDR}, 0);
        if (!rst_n) begin
            check("rst_a_ready", a_req_ready, 0);
            check("rst_b_ready", b_req_ready, 0);
            check("rst_mem_en", mem_EN, 0);
            check("rst_init_done", init_done, 0);
            check("rst_a_rsp_valid", a_rsp_valid, 0);
            check("rst_b_rsp_valid", b_rsp_valid, 0);
            check("rst_a_rdata", a_rsp_rdata, 0);
            check("rst_b_rdata", b_rsp_rdata, 0);
            exp_q.delete();
            m_last_b   = 1;
            m_a_rdata  = '0;
            m_b_rdata  = '0;
            hold_known = 0;
`ifdef EF_SRAM_ARB_SCRUB_EN
            need_zero  = 1;
`endif
        end else begin
            check("init_done", init_done, edges >= INIT_EDGES);
            if (edges < INIT_EDGES) begin
                check("init_a_ready", a_req_ready, 0);
                check("init_b_ready", b_req_ready, 0);
`ifdef EF_SRAM_ARB_SCRUB_EN
                if (edges >= 1) begin
                    check("scrub_en", mem_EN, 1);
                    check("scrub_rwb", mem_R_WB, 0);
                    check("scrub_ad", mem_AD, edges - 1);
                    check("scrub_di", mem_DI, 0);
                    check("scrub_ben", mem_BEN, 32'hFFFF_FFFF);
                    hold_known = 1;
                    h_ad  = NA'(edges - 1);
                    h_di  = '0;
                    h_ben = '1;
                end else
`endif
                check("init_idle_en", mem_EN, 0);
            end else begin
                if (need_zero) begin
                    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
                    need_zero = 0;
                end
                ga = a_req_valid && (!b_req_valid || m_last_b);
                gb = b_req_valid && !ga;
                check("a_ready", a_req_ready, ga);
                check("b_ready", b_req_ready, gb);
                check("mem_en", mem_EN, ga || gb);
                if (ga || gb) begin
                    we = ga ? a_req_we    : b_req_we;
                    ad = ga ? a_req_addr  : b_req_addr;
                    wd = ga ? a_req_wdata : b_req_wdata;
                    wm = ga ? a_req_wmask : b_req_wmask;
                    check("mem_ad", mem_AD, ad);
                    check("mem_rwb", mem_R_WB, !we);
                    if (we) begin
                        check("mem_di", mem_DI, wd);
                        check("mem_ben", mem_BEN, wm);
                        ref_mem[ad] = (ref_mem[ad] & ~wm) | (wd & wm);
                    end else begin
                        e.port_b = gb;
                        e.data   = ref_mem[ad];
                        e.due    = cyc + 2;
                        exp_q.push_back(e);
                    end
                    m_last_b   = gb;
                    hold_known = 1;
                    h_ad  = ad;
                    h_di  = wd;
                    h_ben = wm;
                end else if (hold_known) begin
                    check("hold_ad", mem_AD, h_ad);
                    check("hold_di", mem_DI, h_di);
                    check("hold_ben", mem_BEN, h_ben);
                end
            end
            exp_av = 0;
            exp_bv = 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.port_b) begin exp_bv = 1; m_b_rdata = e.data; end
                else          begin exp_av = 1; m_a_rdata = e.data; end
            end
            check("a_rsp_valid", a_rsp_valid, exp_av);
            check("b_rsp_valid", b_rsp_valid, exp_bv);
            check("a_rsp_rdata", a_rsp_rdata, m_a_rdata);
            check("b_rsp_rdata", b_rsp_rdata, m_b_rdata);
        end
    end

    // Drive one request (called at posedge+2), wait for its grant, then drop valid.
    task automatic issue(input bit pb, input bit we, input logic [NA-1:0] ad,
                         input logic [NB-1:0] wd, input logic [NB-1:0] wm, output int acc);
        int n;
        bit done;
        if (pb) begin
            b_req_we = we; b_req_addr = ad; b_req_wdata = wd; b_req_wmask = wm; b_req_valid = 1;
        end else begin
            a_req_we = we; a_req_addr = ad; a_req_wdata = wd; a_req_wmask = wm; a_req_valid = 1;
        end
        done = 0;
        n    = 0;
        acc  = -1;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (pb ? b_req_ready : a_req_ready) begin
                done = 1;
                acc  = cyc;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: port %0d got no grant, required one within 3000 cycles", pb);
        end
        @(posedge clk);
        #2;
        if (pb) b_req_valid = 0;
        else    a_req_valid = 0;
    endtask

    initial begin : stim
        int          acc, n;
        logic [3:0]  gseq;
        rst_n = 0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_req_wmask = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        n = 0;
        while (!init_done && n < NW + 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;

        // 1: write then read-after-write on A
        issue(0, 1, 10'h005, 32'hDEAD_BEEF, 32'hFFFF_FFFF, acc);
        issue(0, 0, 10'h005, 32'h0, 32'hFFFF_FFFF, acc);
        @(negedge clk);
        check("t1_valid_early", a_rsp_valid, 0);
        @(negedge clk);
        check("t1_valid", a_rsp_valid, 1);
        check("t1_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;

        // 2: B grant first, then 4 cycles of contention -> A,B,A,B
        issue(1, 1, 10'h100, 32'h0BAD_F00D, 32'hFFFF_FFFF, acc);
        a_req_we = 0; a_req_addr = 10'h010;
        b_req_we = 0; b_req_addr = 10'h020;
        a_req_valid = 1; b_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gseq[i] = b_req_ready;
            check("t2_mem_en", mem_EN, 1);
            @(posedge clk);
            #2;
        end
        a_req_valid = 0; b_req_valid = 0;
        check("t2_order", gseq, 4'b1010);
        @(negedge clk);
        check("t2_a_last_valid", a_rsp_valid, 1);
        @(negedge clk);
        check("t2_b_last_valid", b_rsp_valid, 1);
        check("t2_b_rdata", b_rsp_rdata, EXP_RD20);
        @(posedge clk);
        #2;

        // 3: bit mask on the top address
        issue(0, 1, 10'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        issue(1, 1, 10'h3FF, 32'h0000_0000, 32'h0000_FFFF, acc);
        issue(0, 0, 10'h3FF, 32'h0, 32'hFFFF_FFFF, acc);
        @(negedge clk);
        @(negedge clk);
        check("t3_valid", a_rsp_valid, 1);
        check("t3_rdata", a_rsp_rdata, 32'hFFFF_0000);
        @(posedge clk);
        #2;

        // 4/5/6: reset one cycle after a B read accept
        issue(1, 0, 10'h020, 32'h0, 32'hFFFF_FFFF, acc);
        rst_n = 0;
        a_req_we = 0; a_req_addr = 10'h3FF; a_req_valid = 1;
        b_req_we = 0; b_req_addr = 10'h005; b_req_valid = 1;
        @(negedge clk);
        check("t4_rst_en", mem_EN, 0);
        check("t4_rst_ready", {a_req_ready, b_req_ready}, 0);
        check("t4_rst_init", init_done, 0);
        @(posedge clk);
        #2;
`ifdef EF_SRAM_ARB_SCRUB_EN
        poke = 1; poke_addr = 10'h3FF; poke_data = 32'h1234_5678;
`endif
        @(negedge clk);
        check("t4_no_b_rsp", b_rsp_valid, 0);
        @(posedge clk);
        #2 poke = 0;
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        n = 0;
        while (!init_done && n < NW + 20) begin
            n++;
            @(negedge clk);
        end
        check("t6_init_edges", n, INIT_EDGES);
        check("t4_a_first", a_req_ready, 1);
        check("t4_b_waits", b_req_ready, 0);
        @(posedge clk);
        #2 a_req_valid = 0;
        @(negedge clk);
        check("t4_b_second", b_req_ready, 1);
        @(posedge clk);
        #2 b_req_valid = 0;
        @(negedge clk);
        check("t5_valid", a_rsp_valid, 1);
        check("t5_rdata_3ff", a_rsp_rdata, EXP_3FF_RST);
        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
